// File: rtl/instr_fetch.sv
// Fetch stage: issues in-order word requests at the PC, queues returned words
// with their PC for decode, and steers the PC block (advance, hold or redirect).
module instr_fetch #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc_in,
   output logic            pc_en,
   output logic [XLEN-1:0] pc_next,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

   logic [XLEN-1:0] iq_pc    [DEPTH];
   logic [XLEN-1:0] iq_instr [DEPTH];
   logic [XLEN-1:0] pq       [DEPTH];
   logic [PW-1:0]   iq_rd, iq_wr, pq_rd, pq_wr;
   logic [CW-1:0]   qcnt, inflight, drop_cnt;
   logic [CW:0]     occupancy;
   logic            fire, rsp_take, rsp_keep, pop;

   // Handshakes: a transfer happens on a cycle where valid and ready are both 1;
   // valid never depends on ready. Memory responses have no ready and are
   // consumed the cycle they are presented.
   assign occupancy      = {1'b0, inflight} + {1'b0, qcnt};
   assign imem_req_valid = !rst && !redirect_valid && (occupancy < DEPTH_C);
   assign imem_req_addr  = pc_in;
   assign fire           = imem_req_valid && imem_req_ready;

   // A response with nothing outstanding is stale (pre-reset) and is ignored.
   assign rsp_take = imem_rsp_valid && (inflight != '0);
   assign rsp_keep = rsp_take && (drop_cnt == '0);

   assign if_valid = !rst && (qcnt != '0) && !redirect_valid;
   assign pop      = if_valid && if_ready;
   assign if_instr = (qcnt != '0) ? iq_instr[iq_rd] : '0;
   assign if_pc    = (qcnt != '0) ? iq_pc[iq_rd]    : '0;

   always_comb begin
      pc_en   = 1'b1;
      pc_next = pc_in;
      if (rst) begin
         pc_en   = 1'b0;
         pc_next = '0;
      end else if (redirect_valid) begin
         pc_next = redirect_pc;
      end else if (fire) begin
         pc_en = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         iq_rd    <= '0;
         iq_wr    <= '0;
         pq_rd    <= '0;
         pq_wr    <= '0;
         qcnt     <= '0;
         inflight <= '0;
         drop_cnt <= '0;
      end else begin
         inflight <= inflight + CW'(fire) - CW'(rsp_take);
         if (redirect_valid) begin
            // Everything still outstanding after this cycle belongs to the old path.
            iq_rd    <= '0;
            iq_wr    <= '0;
            pq_rd    <= '0;
            pq_wr    <= '0;
            qcnt     <= '0;
            drop_cnt <= inflight - CW'(rsp_take);
         end else begin
            if (fire) begin
               pq[pq_wr] <= pc_in;
               pq_wr     <= pq_wr + 1'b1;
            end
            if (rsp_take && (drop_cnt != '0)) begin
               drop_cnt <= drop_cnt - 1'b1;
            end
            if (rsp_keep) begin
               iq_pc[iq_wr]    <= pq[pq_rd];
               iq_instr[iq_wr] <= imem_rsp_data;
               iq_wr           <= iq_wr + 1'b1;
               pq_rd           <= pq_rd + 1'b1;
            end
            if (pop) begin
               iq_rd <= iq_rd + 1'b1;
            end
            qcnt <= qcnt + CW'(rsp_keep) - CW'(pop);
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: PC block and memory models around the DUT, with an
// epoch-tagged reference model feeding an expected queue checked at decode.
`timescale 1ns/1ps
module tb_instr_fetch;

   localparam int XLEN  = 32;
   localparam int DEPTH = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [XLEN-1:0] pc_in = '0;
   logic            pc_en;
   logic [XLEN-1:0] pc_next;
   logic            imem_req_valid;
   logic            imem_req_ready = 1'b0;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid = 1'b0;
   logic [XLEN-1:0] imem_rsp_data = '0;
   logic            if_valid;
   logic            if_ready = 1'b0;
   logic [XLEN-1:0] if_instr;
   logic [XLEN-1:0] if_pc;
   logic            redirect_valid = 1'b0;
   logic [XLEN-1:0] redirect_pc = '0;

   instr_fetch #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .pc_in(pc_in), .pc_en(pc_en), .pc_next(pc_next),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .if_valid(if_valid), .if_ready(if_ready),
      .if_instr(if_instr), .if_pc(if_pc), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- environment and reference model ----------------
   typedef struct {
      logic [XLEN-1:0] addr;
      int              ready_at;
      int              epoch;
      bit              counted;
   } mem_req_t;

   logic [XLEN-1:0]   mem [256];
   mem_req_t          mem_q[$];
   mem_req_t          cur_rsp;
   bit                cur_rsp_v = 0;
   logic [2*XLEN-1:0] exp_q[$];
   int                cyc = 0;
   int                epoch = 0;
   int                n_arrived = 0;
   int                lat_min = 1;
   int                lat_max = 1;
   int                fire_cnt = 0;
   logic [XLEN-1:0]   exp_fetch_pc = '0;
   logic [XLEN-1:0]   nxt_pc = '0;
   bit                nxt_rsp_v = 0;
   logic [XLEN-1:0]   nxt_rsp_data = '0;
   int                n_checks = 0;
   int                n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Responses the DUT still counts as outstanding but that belong to an old path.
   function automatic int doomed_cnt();
      int n = 0;
      foreach (mem_q[i]) if (mem_q[i].counted && mem_q[i].epoch != epoch) n++;
      if (cur_rsp_v && cur_rsp.counted && cur_rsp.epoch != epoch) n++;
      return n;
   endfunction

   always @(negedge clk) begin : env
      bit              fire_s;
      bit              exp_rv;
      int              occ;
      int              lat;
      logic [63:0]     head;
      mem_req_t        req;
      cyc++;
      fire_s = imem_req_valid && imem_req_ready;
      if (rst) begin
         check("rst_req_valid", imem_req_valid, 0);
         check("rst_if_valid", if_valid, 0);
         check("rst_pc_en", pc_en, 0);
         check("rst_pc_next", pc_next, 0);
         foreach (mem_q[i]) mem_q[i].counted = 0;
         exp_q.delete();
         n_arrived = 0;
         epoch++;
         exp_fetch_pc = '0;
         nxt_pc = '0;
      end else begin
         occ    = doomed_cnt() + exp_q.size();
         exp_rv = !redirect_valid && (occ < DEPTH);
         check("req_valid", imem_req_valid, exp_rv);
         check("if_valid", if_valid, !redirect_valid && (n_arrived > 0));
         if (redirect_valid) begin
            check("redir_pc_ctl", {pc_en, pc_next}, {1'b1, redirect_pc});
         end else if (fire_s) begin
            check("advance_pc_en", pc_en, 0);
         end else begin
            check("hold_pc_ctl", {pc_en, pc_next}, {1'b1, pc_in});
         end
         if (n_arrived == 0) check("empty_head", {if_pc, if_instr}, 0);
         if (fire_s) begin
            check("req_addr", imem_req_addr, exp_fetch_pc);
            fire_cnt++;
         end
         // Monitor: every decode handshake retires the oldest expected instruction.
         if (if_valid && if_ready) begin
            if (exp_q.size() == 0) begin
               check("if_out_unexpected", {if_pc, if_instr}, 64'hx);
            end else begin
               head = exp_q.pop_front();
               check("if_out", {if_pc, if_instr}, head);
            end
            if (n_arrived > 0) n_arrived--;
         end
         if (cur_rsp_v && cur_rsp.counted && cur_rsp.epoch == epoch) n_arrived++;
         if (redirect_valid) begin
            epoch++;
            exp_q.delete();
            n_arrived = 0;
            exp_fetch_pc = redirect_pc;
         end else if (fire_s) begin
            exp_q.push_back({exp_fetch_pc, mem[exp_fetch_pc[9:2]]});
            exp_fetch_pc = exp_fetch_pc + 4;
         end
         if (fire_s) begin
            lat          = $urandom_range(lat_max, lat_min);
            req.addr     = imem_req_addr;
            req.ready_at = cyc + lat - 1;
            req.epoch    = epoch;
            req.counted  = 1;
            mem_q.push_back(req);
         end
         nxt_pc = pc_en ? pc_next : pc_in + 4;
      end
      cur_rsp_v = 0;
      if (mem_q.size() > 0 && mem_q[0].ready_at <= cyc) begin
         cur_rsp   = mem_q.pop_front();
         cur_rsp_v = 1;
      end
      nxt_rsp_v    = cur_rsp_v;
      nxt_rsp_data = cur_rsp_v ? mem[cur_rsp.addr[9:2]] : $urandom;
   end

   // PC register and memory response port, updated just after the clock edge.
   always @(posedge clk) begin
      #1;
      pc_in          = nxt_pc;
      imem_rsp_valid = nxt_rsp_v;
      imem_rsp_data  = nxt_rsp_data;
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drain();
      bit idle = 0;
      redirect_valid = 0;
      if_ready       = 1;
      imem_req_ready = 0;
      for (int i = 0; i < 100 && !idle; i++) begin
         tick();
         idle = (mem_q.size() == 0) && !cur_rsp_v && (exp_q.size() == 0);
      end
      check("drain_done", idle, 1);
   endtask

   task automatic do_reset();
      rst = 1;
      repeat (2) tick();
      fire_cnt = 0;
      rst = 0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bit seen;
      foreach (mem[i]) mem[i] = $urandom;

      // Streaming with single-cycle memory and an always-ready decoder.
      lat_min = 1; lat_max = 1;
      imem_req_ready = 1; if_ready = 1;
      do_reset();
      repeat (12) tick();
      drain();

      // Decoder stalled: two requests fill the stage, then the PC holds.
      if_ready = 0; imem_req_ready = 1;
      do_reset();
      repeat (8) tick();
      check("stall_fire_cnt", fire_cnt, 2);
      check("stall_pc_hold", pc_in, 32'h8);
      if_ready = 1;
      repeat (8) tick();
      drain();

      // Redirect with two slow requests in flight.
      lat_min = 3; lat_max = 3;
      imem_req_ready = 1; if_ready = 1;
      do_reset();
      repeat (2) tick();
      redirect_valid = 1; redirect_pc = 32'h40;
      tick();
      redirect_valid = 0;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = if_valid;
      end
      check("redirect_wait", seen, 1);
      if (seen) check("redirect_first_pc", if_pc, 32'h40);
      tick();
      drain();

      // Redirect on a cycle with a response arriving and the stage full.
      lat_min = 1; lat_max = 1;
      imem_req_ready = 1; if_ready = 0;
      do_reset();
      repeat (2) tick();
      redirect_valid = 1; redirect_pc = 32'h100;
      tick();
      redirect_valid = 0;
      @(negedge clk);
      check("restart_req_valid", imem_req_valid, 1);
      check("restart_addr", imem_req_addr, 32'h100);
      tick();
      if_ready = 1;
      repeat (6) tick();
      drain();

      // Memory not ready: request held stable and PC held.
      imem_req_ready = 0; if_ready = 1;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("nrdy_req_valid", imem_req_valid, 1);
         check("nrdy_addr", imem_req_addr, 32'h0);
         check("nrdy_pc_in", pc_in, 32'h0);
      end
      tick();
      imem_req_ready = 1;
      repeat (6) tick();
      drain();

      // Reset with requests in flight; stale responses arrive afterwards.
      lat_min = 5; lat_max = 5;
      imem_req_ready = 1; if_ready = 1;
      do_reset();
      repeat (2) tick();
      rst = 1;
      imem_req_ready = 0;
      tick();
      rst = 0;
      repeat (8) tick();
      imem_req_ready = 1;
      @(negedge clk);
      check("post_rst_first_addr", imem_req_addr, 32'h0);
      tick();
      repeat (10) tick();
      drain();

      // Randomized traffic with occasional redirects.
      lat_min = 1; lat_max = 4;
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         imem_req_ready = ($urandom_range(3, 0) != 0);
         if_ready       = ($urandom_range(9, 0) < 7);
         redirect_valid = ($urandom_range(19, 0) == 0);
         redirect_pc    = 32'($urandom_range(255, 0)) << 2;
         tick();
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
